conv_enc_punct: RTL and testbench



---
 rtl/conv_enc_punct.sv | 197 +++++++++++++++++++
 tb/tb_conv_enc_punct.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_enc_punct.sv
// Rate-1/2 convolutional encoder with 1/2, 2/3 and 3/4 puncturing, frame delimiting and valid/ready flow control.
// Define CONV_ENC_TAIL_EN to append K-1 zero tail bits to every completed frame.
module conv_enc_punct #(
    parameter int unsigned    K  = 7,
    parameter logic [K-1:0]   G0 = 7'o133,
    parameter logic [K-1:0]   G1 = 7'o171
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [1:0]  rate_i,
    input  logic        sof_i,
    input  logic        eof_i,
    input  logic        data_in,
    input  logic        data_valid_i,
    output logic        data_ready_o,
    output logic [1:0]  data_out,
    output logic [1:0]  data_mask_o,
    output logic        data_valid_o,
    output logic        data_last_o,
    input  logic        data_ready_i
);

    localparam int unsigned SR_W = K - 1;
    localparam int unsigned TC_W = (SR_W > 1) ? $clog2(SR_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [SR_W-1:0]   r_sr, w_sr_nxt, w_sr_use;
    logic [1:0]        r_p, w_p_nxt, w_p_use;
    logic [1:0]        r_rate, w_rate_nxt, w_rate_use;
    logic [1:0]        r_data, w_data_nxt;
    logic [1:0]        r_mask, w_mask_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_last, w_last_nxt;
    logic              w_load, w_accept, w_enc, w_bit, w_is_last;
`ifdef CONV_ENC_TAIL_EN
    logic [TC_W-1:0]   r_tcnt, w_tcnt_nxt;
`endif

    function automatic logic parity(input logic [K-1:0] g, input logic b, input logic [SR_W-1:0] sr);
        logic acc;
        acc = g[K-1] & b;
        for (int unsigned i = 0; i < SR_W; i++) begin
            acc = acc ^ (g[K-2-i] & sr[i]);
        end
        return acc;
    endfunction

    function automatic logic [1:0] punct_mask(input logic [1:0] rate, input logic [1:0] p);
        logic [1:0] m;
        m = 2'b11;
        if (rate == 2'b01) begin
            m = (p == 2'd0) ? 2'b11 : 2'b01;
        end else if (rate == 2'b10) begin
            m = (p == 2'd0) ? 2'b11 : ((p == 2'd1) ? 2'b01 : 2'b10);
        end
        return m;
    endfunction

    function automatic logic [1:0] punct_next(input logic [1:0] rate, input logic [1:0] p);
        logic [1:0] n;
        n = 2'd0;
        if (rate == 2'b01) begin
            n = (p == 2'd0) ? 2'd1 : 2'd0;
        end else if (rate == 2'b10) begin
            n = (p == 2'd2) ? 2'd0 : 2'(p + 2'd1);
        end
        return n;
    endfunction

    // Output register may load whenever it is empty or being drained this cycle.
    assign w_load = !r_valid || data_ready_i;
`ifdef CONV_ENC_TAIL_EN
    assign data_ready_o = (r_state != S_TAIL) && w_load;
`else
    assign data_ready_o = w_load;
`endif
    assign w_accept = data_valid_i && data_ready_o;

    assign data_out     = r_data;
    assign data_mask_o  = r_mask;
    assign data_valid_o = r_valid;
    assign data_last_o  = r_last;

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_p_nxt     = r_p;
        w_rate_nxt  = r_rate;
        w_data_nxt  = r_data;
        w_mask_nxt  = r_mask;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_sr_use    = r_sr;
        w_p_use     = r_p;
        w_rate_use  = r_rate;
        w_enc       = 1'b0;
        w_bit       = 1'b0;
        w_is_last   = 1'b0;
`ifdef CONV_ENC_TAIL_EN
        w_tcnt_nxt  = r_tcnt;
`endif

        if (w_load) begin
            w_valid_nxt = 1'b0;
            w_data_nxt  = 2'b00;
            w_mask_nxt  = 2'b00;
            w_last_nxt  = 1'b0;
        end

        // A sof beat starts (or restarts) a frame from a cleared encoder in any accepting state.
        if (w_accept && (sof_i || (r_state == S_DATA))) begin
            w_enc = 1'b1;
            w_bit = data_in;
            if (sof_i) begin
                w_sr_use   = '0;
                w_p_use    = 2'd0;
                w_rate_use = (rate_i == 2'b11) ? 2'b00 : rate_i;
                w_rate_nxt = w_rate_use;
            end
            w_state_nxt = S_DATA;
            if (eof_i) begin
`ifdef CONV_ENC_TAIL_EN
                w_state_nxt = S_TAIL;
                w_tcnt_nxt  = '0;
`else
                w_state_nxt = S_IDLE;
                w_is_last   = 1'b1;
`endif
            end
        end

`ifdef CONV_ENC_TAIL_EN
        if ((r_state == S_TAIL) && w_load) begin
            w_enc = 1'b1;
            w_bit = 1'b0;
            if (r_tcnt == TC_W'(SR_W - 1)) begin
                w_is_last   = 1'b1;
                w_state_nxt = S_IDLE;
            end else begin
                w_tcnt_nxt  = TC_W'(r_tcnt + TC_W'(1));
            end
        end
`endif

        if (w_enc) begin
            w_data_nxt  = {parity(G1, w_bit, w_sr_use), parity(G0, w_bit, w_sr_use)};
            w_mask_nxt  = punct_mask(w_rate_use, w_p_use);
            w_valid_nxt = 1'b1;
            w_last_nxt  = w_is_last;
            w_sr_nxt    = {w_sr_use[SR_W-2:0], w_bit};
            w_p_nxt     = punct_next(w_rate_use, w_p_use);
            if (w_is_last) begin
                w_sr_nxt = '0;
                w_p_nxt  = 2'd0;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_p     <= 2'd0;
            r_rate  <= 2'b00;
            r_data  <= 2'b00;
            r_mask  <= 2'b00;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_p     <= w_p_nxt;
            r_rate  <= w_rate_nxt;
            r_data  <= w_data_nxt;
            r_mask  <= w_mask_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
        end
    end

`ifdef CONV_ENC_TAIL_EN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= w_tcnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_conv_enc_punct.sv
// Scoreboard bench for conv_enc_punct; expected beats come from the hand-derived rate-1/2 impulse response.
module tb_conv_enc_punct;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [1:0] rate_i;
    logic       sof_i, eof_i, data_in, data_valid_i, data_ready_o;
    logic [1:0] data_out, data_mask_o;
    logic       data_valid_o, data_last_o, data_ready_i;

    conv_enc_punct dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .rate_i       (rate_i),
        .sof_i        (sof_i),
        .eof_i        (eof_i),
        .data_in      (data_in),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .data_out     (data_out),
        .data_mask_o  (data_mask_o),
        .data_valid_o (data_valid_o),
        .data_last_o  (data_last_o),
        .data_ready_i (data_ready_i)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [1:0] d;
        logic [1:0] m;
        logic       l;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    string      test_name = "reset";
    // {B,A} response to a single 1 followed by zeros (G0=133, G1=171).
    logic [1:0] imp [0:6] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, got, want);
        end
    endtask

    // Expected beats for a frame: XOR of shifted impulse responses, masks by beat index.
    task automatic push_exp(input logic [31:0] bits, input int n, input logic [1:0] rate, input bit complete);
        int   total;
        exp_t e;
        total = n;
`ifdef CONV_ENC_TAIL_EN
        if (complete) total = n + 6;
`endif
        for (int j = 0; j < total; j++) begin
            e.d = 2'b00;
            for (int k = 0; k < n; k++) begin
                if (bits[k] && (j - k >= 0) && (j - k < 7)) e.d = e.d ^ imp[j-k];
            end
            if (rate == 2'b01)      e.m = (j % 2 == 0) ? 2'b11 : 2'b01;
            else if (rate == 2'b10) e.m = (j % 3 == 0) ? 2'b11 : ((j % 3 == 1) ? 2'b01 : 2'b10);
            else                    e.m = 2'b11;
            e.l = complete && (j == total - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input logic sof, input logic eof, input logic d, input logic [1:0] rate);
        sof_i = sof; eof_i = eof; data_in = d; rate_i = rate; data_valid_i = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge sys_clk);
            if (data_ready_o) begin
                @(posedge sys_clk); #1;
                data_valid_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
                return;
            end
        end
        n_cmp++; n_bad++;
        $display("FAIL %s: input beat not accepted within 200 cycles", test_name);
        data_valid_i = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] bits, input int n, input logic [1:0] rate);
        push_exp(bits, n, rate, 1'b1);
        for (int k = 0; k < n; k++) send(k == 0, k == n - 1, bits[k], rate);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 300; t++) begin
            @(negedge sys_clk);
            if (exp_q.size() == 0 && !data_valid_o) begin
                @(posedge sys_clk); #1;
                return;
            end
        end
        n_cmp++; n_bad++;
        $display("FAIL %s: %0d expected beats never appeared", test_name, exp_q.size());
        exp_q.delete();
        @(posedge sys_clk); #1;
    endtask

    // Monitor: compare every consumed beat against the scoreboard head.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (data_valid_o && data_ready_i) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s: unexpected beat data=%b mask=%b last=%b", test_name, data_out, data_mask_o, data_last_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ({data_out, data_mask_o, data_last_o} !== e) begin
                        n_bad++;
                        $display("FAIL %s: got data=%b mask=%b last=%b, expected data=%b mask=%b last=%b",
                                 test_name, data_out, data_mask_o, data_last_o, e.d, e.m, e.l);
                    end
                end
            end else if (!data_valid_o) begin
                n_cmp++;
                if ({data_out, data_mask_o, data_last_o} !== 5'b0) begin
                    n_bad++;
                    $display("FAIL %s_idle_zero: got data=%b mask=%b last=%b, expected all 0",
                             test_name, data_out, data_mask_o, data_last_o);
                end
            end
        end
    end

    initial begin
        sys_rst = 1'b1; rate_i = 2'b00; sof_i = 1'b0; eof_i = 1'b0;
        data_in = 1'b0; data_valid_i = 1'b0; data_ready_i = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset_outputs", {3'b0, data_out, data_mask_o, data_valid_o}, 8'h00);
        check("reset_last", {7'b0, data_last_o}, 8'h00);
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        check("ready_after_reset", {7'b0, data_ready_o}, 8'h01);

        test_name = "idle_drop";
        send(1'b0, 1'b0, 1'b1, 2'b00);
        send(1'b0, 1'b1, 1'b1, 2'b00);
        repeat (4) @(posedge sys_clk);
        #1;

        test_name = "impulse_r12";
        send_frame(32'h1, 1, 2'b00);
        wait_drain();

        test_name = "impulse_r34";
        send_frame(32'h1, 1, 2'b10);
        wait_drain();

        test_name = "zeros_r23";
        send_frame(32'h0, 24, 2'b01);
        wait_drain();

        test_name = "impulse_rate11";
        send_frame(32'h1, 1, 2'b11);
        wait_drain();

        test_name = "mixed_r23";
        send_frame(32'hB, 4, 2'b01);
        wait_drain();

        // Stall the first output for 5 cycles; it must hold and block input.
        test_name = "backpressure";
        push_exp(32'h5, 3, 2'b00, 1'b1);
        data_ready_i = 1'b0;
        send(1'b1, 1'b0, 1'b1, 2'b00);
        for (int c = 0; c < 5; c++) begin
            @(negedge sys_clk);
            check("stall_valid_data", {5'b0, data_valid_o, data_out}, 8'h07);
            check("stall_ready_o", {7'b0, data_ready_o}, 8'h00);
        end
        @(posedge sys_clk); #1;
        data_ready_i = 1'b1;
        send(1'b0, 1'b0, 1'b0, 2'b00);
        send(1'b0, 1'b1, 1'b1, 2'b00);
        wait_drain();

        test_name = "abort";
        push_exp(32'h3, 2, 2'b10, 1'b0);
        send(1'b1, 1'b0, 1'b1, 2'b10);
        send(1'b0, 1'b0, 1'b1, 2'b10);
        push_exp(32'h1, 1, 2'b00, 1'b1);
        send(1'b1, 1'b1, 1'b1, 2'b00);
        wait_drain();

        // Reset while a frame is pending in the output stage (tail pending when enabled).
        test_name = "reset_mid_frame";
        data_ready_i = 1'b0;
        send(1'b1, 1'b1, 1'b1, 2'b00);
        @(negedge sys_clk);
        check("pre_reset_valid", {7'b0, data_valid_o}, 8'h01);
        @(posedge sys_clk); #3;
        sys_rst = 1'b1;
        #1;
        check("mid_reset_outputs", {3'b0, data_out, data_mask_o, data_valid_o}, 8'h00);
        check("mid_reset_last", {7'b0, data_last_o}, 8'h00);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        exp_q.delete();
        data_ready_i = 1'b1;
        @(posedge sys_clk); #1;

        test_name = "impulse_after_reset";
        send_frame(32'h1, 1, 2'b00);
        wait_drain();

        test_name = "final";
        check("scoreboard_empty", 8'(exp_q.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
